// File: rtl/stochastic_stream_gen.sv
// Stochastic number generator: turns two unsigned operands plus a fixed ~50% threshold into
// unipolar serial bitstreams, one bit per clock, over a frame of STREAM_LEN cycles.
module stochastic_stream_gen #(
    parameter int               WIDTH      = 8,
    parameter int               STREAM_LEN = (1 << WIDTH) - 1,
    parameter logic [WIDTH-1:0] SEED_A     = WIDTH'(8'h01),
    parameter logic [WIDTH-1:0] SEED_B     = WIDTH'(8'hA5),
    parameter logic [WIDTH-1:0] SEED_S     = WIDTH'(8'h3C)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] value_a,
    input  logic [WIDTH-1:0] value_b,
    output logic             serial_line1,
    output logic             serial_line2,
    output logic             sel,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    localparam int               CW       = $clog2(STREAM_LEN + 1);
    localparam logic [CW-1:0]    LAST_IDX = CW'(STREAM_LEN - 1);
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    // Tap masks: bits 8,6,5,4 (WIDTH=8) or 16,15,13,4 (WIDTH=16), numbered from 1.
    localparam logic [WIDTH-1:0] TAPS     = (WIDTH == 16) ? WIDTH'(16'hD008) : WIDTH'(8'hB8);
    localparam logic [WIDTH-1:0] SEL_TH   = WIDTH'((1 << (WIDTH - 1)) - 1);
    localparam logic [WIDTH-1:0] INIT_A   = (SEED_A == '0) ? ONE : SEED_A;
    localparam logic [WIDTH-1:0] INIT_B   = (SEED_B == '0) ? ONE : SEED_B;
    localparam logic [WIDTH-1:0] INIT_S   = (SEED_S == '0) ? ONE : SEED_S;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] s);
        return {s[WIDTH-2:0], ^(s & TAPS)};
    endfunction

    state_t           state, state_nx;
    logic [WIDTH-1:0] lfsr_a, lfsr_b, lfsr_s;
    logic [WIDTH-1:0] val_a, val_b;
    logic [CW-1:0]    cnt;
    logic             emit, load;

    // Next-state decode; emit marks cycles that produce a stream bit.
    always_comb begin
        state_nx = state;
        emit     = 1'b0;
        load     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_RUN;
                    load     = 1'b1;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            S_RUN: begin
                emit = 1'b1;
                if (cnt == LAST_IDX) begin
                    state_nx = S_DONE;
                end else begin
                    state_nx = S_RUN;
                end
            end
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // State, operand latches, LFSRs and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            lfsr_a       <= INIT_A;
            lfsr_b       <= INIT_B;
            lfsr_s       <= INIT_S;
            val_a        <= '0;
            val_b        <= '0;
            cnt          <= '0;
            serial_line1 <= 1'b0;
            serial_line2 <= 1'b0;
            sel          <= 1'b0;
            valid        <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state <= state_nx;
            if (load) begin
                val_a <= value_a;
                val_b <= value_b;
                cnt   <= '0;
            end else if (emit) begin
                cnt <= cnt + CW'(1);
            end
            // The generators only move when a bit leaves, so frames chain without reseeding.
            if (emit) begin
                lfsr_a <= lfsr_next(lfsr_a);
                lfsr_b <= lfsr_next(lfsr_b);
                lfsr_s <= lfsr_next(lfsr_s);
            end
            serial_line1 <= emit & (lfsr_a <= val_a);
            serial_line2 <= emit & (lfsr_b <= val_b);
            sel          <= emit & (lfsr_s <= SEL_TH);
            valid        <= emit;
            busy         <= (state_nx != S_IDLE);
            done         <= (state == S_DONE);
        end
    end

endmodule
